// File: rtl/decoder_2_to_4_sequential.sv
`default_nettype none
// ============================================================================
// Module   : decoder_2_to_4_sequential
// Purpose  : FIFO-buffered 2-to-4 decoder that replays each code as a
//            one-hot strobe held for HOLD_CYCLES cycles.
// Option   : define DEC_GAP_EN to insert one all-zero cycle between codes.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_2_to_4_sequential #(
    parameter int HOLD_CYCLES = 4,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   in_lines,
    input  logic                         in_none,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [3:0]                   out_lines,
    output logic                         out_valid,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1
`ifdef DEC_GAP_EN
        ,
        ST_GAP   = 2'd2
`endif
    } state_t;

    // Entry layout: {none, code[1:0]}
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    lines_q, lines_d;
    logic          valid_q, valid_d;

    logic          w_full, w_empty, w_push, w_pop;
    logic [2:0]    w_head;

    assign w_full  = (level_q == LW'(DEPTH));
    assign w_empty = (level_q == '0);
    assign w_push  = in_valid && !w_full;
    assign w_head  = mem_q[rd_ptr_q];

    function automatic logic [3:0] decode(input logic [2:0] entry);
        return entry[2] ? 4'b0000 : (4'b0001 << entry[1:0]);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        valid_d = valid_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
`ifdef DEC_GAP_EN
                    state_d = ST_GAP;
                    lines_d = 4'b0000;
                    valid_d = 1'b0;
`else
                    // Reload straight from the FIFO so codes run back-to-back
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        lines_d = decode(w_head);
                        valid_d = 1'b1;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                        lines_d = 4'b0000;
                        valid_d = 1'b0;
                    end
`endif
                end
            end
            default: begin
                // IDLE, and GAP which behaves as IDLE after its zero cycle
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = ST_DRIVE;
                    lines_d = decode(w_head);
                    valid_d = 1'b1;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                    lines_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lines_q  <= 4'b0000;
            valid_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            valid_q <= valid_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy tracking makes stale entries unreachable
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= {in_none, in_lines};
    end

    assign in_ready  = !w_full;
    assign out_lines = lines_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != ST_IDLE) || !w_empty;
    assign level     = level_q;

endmodule
`default_nettype wire

// File: doc/decoder_2_to_4_sequential.md
# decoder_2_to_4_sequential

Sequential 2-to-4 line decoder, the inverse of the team's 4-to-2 priority encoder. It accepts 2-bit line codes through a valid/ready handshake and buffers them in a small FIFO. Each code is regenerated as a one-hot pulse on the 4 output lines, held for a fixed number of cycles. It sits downstream of the encoder to re-expand its compressed codes into timed line strobes.

## Interface
- HOLD_CYCLES, 4: cycles each decoded line stays asserted; legal range 1..255.
- DEPTH, 4: code FIFO depth; power of 2, at least 2.

- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- in_lines  input  2  code to decode; 2'b11 selects out_lines[3].
- in_none  input  1  marks a "no line active" code; produces an all-zero hold period.
- in_valid  input  1  code/in_none valid.
- in_ready  output  1  FIFO can accept; equals !full.
- out_lines  output  4  registered one-hot decoded lines.
- out_valid  output  1  high while a code's hold period is being driven, including in_none codes.
- busy  output  1  high when the state is not IDLE or the FIFO is not empty.
- level  output  clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Push: on a clk edge with in_valid && in_ready, write {in_none, in_lines} at the write pointer.
- in_ready is a function of full only. When the FIFO is full, no push occurs, even if a pop happens in the same cycle.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty come from level, which is +1 on push, -1 on pop, and unchanged when both occur.
- FSM states: IDLE, DRIVE, and GAP (GAP exists only with the macro).
- IDLE:
  - If the FIFO is non-empty, pop the head and go to DRIVE.
  - out_lines is 1 << code, or 4'b0000 if in_none. out_valid = 1. The hold counter loads HOLD_CYCLES-1.
  - If the FIFO is empty, out_lines = 0 and out_valid = 0.
- DRIVE:
  - While the counter is not 0, decrement it and hold the outputs.
  - When the counter is 0 and the FIFO is non-empty, pop the next entry and reload directly. The two codes are contiguous with no idle cycle.
  - When the counter is 0 and the FIFO is empty, clear the outputs and go to IDLE.
- out_lines never has more than one bit set.

## Timing
- Reset values: out_lines = 4'b0000, out_valid = 0, in_ready = 1, busy = 0, level = 0; state IDLE; pointers and counter at 0. FIFO contents are don't-care.
- rst asserted mid-hold: outputs are zero on the cycle after the reset edge. All buffered codes are discarded. A push presented in the reset cycle is ignored.
- Latency: a code pushed at edge k into an empty, IDLE block appears on out_lines after edge k+1.
- Each code is held exactly HOLD_CYCLES cycles.
- Sustained throughput is one code per HOLD_CYCLES cycles; with the macro it is one code per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES = 1 with the FIFO kept fed: a new code on every cycle.

## Configuration
- DEC_GAP_EN
  - Defined: DRIVE with counter 0 always goes to GAP. GAP drives out_lines = 0 and out_valid = 0 for one cycle, then acts as IDLE on the next edge. Consecutive codes are therefore separated by exactly one zero cycle.
  - Undefined: the GAP state is not compiled. Back-to-back codes are contiguous as described in Operation.

## Test plan
- Reset, then push 2'b10 with HOLD_CYCLES=4: out_lines = 4'b0100 for exactly 4 cycles starting 2 cycles after the push. Then out_lines returns to 0, and busy drops on the same cycle.
- Push 0,1,2,3 back-to-back with DEPTH=4:
  - level reaches 3 or 4 and in_ready behaves accordingly.
  - Output sequence is 0001, 0010, 0100, 1000, each held 4 cycles and contiguous.
  - With DEC_GAP_EN, one zero cycle separates each pair.
- Fill the FIFO while the block is busy with in_valid held high: in_ready = 0 at level = DEPTH. The extra code is not lost. It is accepted once a pop frees space, is output last, and the cycle before acceptance shows level = DEPTH-1.
- Push with in_none = 1 and in_lines = 2'b11: out_lines = 0000 with out_valid = 1 for HOLD_CYCLES cycles.
- Assert rst 2 cycles into a hold with 2 codes queued: out_lines = 0, level = 0, and busy = 0 on the next cycle. No queued code is emitted afterward.
- HOLD_CYCLES=1 with a continuously fed FIFO, macro off: out_lines changes every cycle with no zero cycles in between.
